// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor BTB: counter encodings,
// address field widths and the table entry record.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int unsigned DEF_ENTRIES = 16;
  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_CTR_W   = 2;

  function automatic int unsigned calc_idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // Tag covers everything above the index field and the ignored byte offset.
  function automatic int unsigned calc_tag_w(input int unsigned entries, input int unsigned addr_w);
    return addr_w - $clog2(entries) - 2;
  endfunction

  typedef struct packed {
    logic                                              valid;
    logic [calc_tag_w(DEF_ENTRIES, DEF_ADDR_W)-1:0]    tag;
    logic [DEF_ADDR_W-1:0]                             target;
    logic [DEF_CTR_W-1:0]                              ctr;
  } bp_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for a W-bit counter that saturates at zero and all-ones.
module sat_counter #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] cur,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt
);

  localparam logic [W-1:0] MAX = '1;

  always_comb begin
    nxt = cur;
    if (inc && !dec && cur != MAX) begin
      nxt = cur + W'(1);
    end else if (dec && !inc && cur != '0) begin
      nxt = cur - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with saturating direction counters;
// combinational lookup for IF, trained by resolved branches from EX.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [ADDR_W-1:0] LKP_PC,
  output logic              PRED_Hit,
  output logic              PRED_Taken,
  output logic [ADDR_W-1:0] PRED_Next_PC,
  input  logic              UPD_Valid,
  input  logic [ADDR_W-1:0] UPD_PC,
  input  logic              UPD_Taken,
  input  logic [ADDR_W-1:0] UPD_Target,
  input  logic              UPD_Mispredict,
  input  logic              FLUSH_All,
  output logic [STAT_W-1:0] STAT_Lookups,
  output logic [STAT_W-1:0] STAT_Mispredicts
);

  localparam int unsigned IDX_W = calc_idx_w(ENTRIES);
  localparam int unsigned TAG_W = calc_tag_w(ENTRIES, ADDR_W);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0]  lkp_idx, upd_idx;
  logic [TAG_W-1:0]  lkp_tag, upd_tag;
  logic              upd_hit;
  logic [CTR_W-1:0]  ctr_nxt;
  logic [STAT_W-1:0] lookups_nxt, mispredicts_nxt;
  logic              unused_lsbs;

  assign lkp_idx     = LKP_PC[IDX_W+1:2];
  assign lkp_tag     = LKP_PC[ADDR_W-1:IDX_W+2];
  assign upd_idx     = UPD_PC[IDX_W+1:2];
  assign upd_tag     = UPD_PC[ADDR_W-1:IDX_W+2];
  assign unused_lsbs = ^{LKP_PC[1:0], UPD_PC[1:0]};

  // Lookup reads the registered table only, so same-cycle updates are not bypassed.
  always_comb begin
    PRED_Hit     = !CLR && valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    PRED_Taken   = PRED_Hit && ctr_q[lkp_idx][CTR_W-1];
    PRED_Next_PC = PRED_Taken ? target_q[lkp_idx] : LKP_PC + ADDR_W'(4);
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  sat_counter #(.W(CTR_W)) u_dir_ctr (
    .cur (ctr_q[upd_idx]),
    .inc (UPD_Taken),
    .dec (!UPD_Taken),
    .nxt (ctr_nxt)
  );

  sat_counter #(.W(STAT_W)) u_lookups (
    .cur (STAT_Lookups),
    .inc (1'b1),
    .dec (1'b0),
    .nxt (lookups_nxt)
  );

  sat_counter #(.W(STAT_W)) u_mispredicts (
    .cur (STAT_Mispredicts),
    .inc (UPD_Valid && UPD_Mispredict),
    .dec (1'b0),
    .nxt (mispredicts_nxt)
  );

  // Priority: CLR, then FLUSH_All, then training update; stats ignore FLUSH_All.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      valid_q          <= '0;
      STAT_Lookups     <= '0;
      STAT_Mispredicts <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      STAT_Lookups     <= lookups_nxt;
      STAT_Mispredicts <= mispredicts_nxt;
      if (FLUSH_All) begin
        valid_q <= '0;
      end else if (UPD_Valid) begin
        if (upd_hit) begin
          ctr_q[upd_idx] <= ctr_nxt;
          if (UPD_Taken) begin
            target_q[upd_idx] <= UPD_Target;
          end
        end else if (UPD_Taken) begin
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= UPD_Target;
          ctr_q[upd_idx]    <= CTR_WT;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed vector table, random
// traffic against an array-based reference model, and stats saturation.
module tb_branch_predictor_btb;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned CTR_W   = 2;
  localparam int unsigned STAT_W  = 4;
  localparam int          STAT_MAX = 15;

  logic              CLK = 1'b0;
  logic              CLR = 1'b1;
  logic [ADDR_W-1:0] LKP_PC = '0;
  logic              PRED_Hit, PRED_Taken;
  logic [ADDR_W-1:0] PRED_Next_PC;
  logic              UPD_Valid = 1'b0;
  logic [ADDR_W-1:0] UPD_PC = '0;
  logic              UPD_Taken = 1'b0;
  logic [ADDR_W-1:0] UPD_Target = '0;
  logic              UPD_Mispredict = 1'b0;
  logic              FLUSH_All = 1'b0;
  logic [STAT_W-1:0] STAT_Lookups, STAT_Mispredicts;

  branch_predictor_btb #(
    .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .CTR_W(CTR_W), .STAT_W(STAT_W)
  ) dut (
    .CLK(CLK), .CLR(CLR), .LKP_PC(LKP_PC),
    .PRED_Hit(PRED_Hit), .PRED_Taken(PRED_Taken), .PRED_Next_PC(PRED_Next_PC),
    .UPD_Valid(UPD_Valid), .UPD_PC(UPD_PC), .UPD_Taken(UPD_Taken),
    .UPD_Target(UPD_Target), .UPD_Mispredict(UPD_Mispredict),
    .FLUSH_All(FLUSH_All),
    .STAT_Lookups(STAT_Lookups), .STAT_Mispredicts(STAT_Mispredicts)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          clr, flush, uv, ut, um;
    logic [31:0] upc, utgt, lpc;
  } in_t;

  typedef struct {
    in_t         i;
    bit          hit, tk;
    logic [31:0] nxt;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: one record per index, counters as plain integers 0..3.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_sl = 0;
  int          m_sm = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic void model_predict(input logic [31:0] pc, input bit clr,
                                        output bit hit, output bit tk, output logic [31:0] nxt);
    int i;
    i   = idx_of(pc);
    hit = !clr && m_valid[i] && (m_tag[i] == tag_of(pc));
    tk  = hit && (m_ctr[i] >= 2);
    nxt = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void model_step(input in_t v);
    int  i;
    bit  hit;
    if (v.clr) begin
      for (int k = 0; k < int'(ENTRIES); k++) begin
        m_valid[k] = 0; m_ctr[k] = 1; m_tgt[k] = '0; m_tag[k] = 0;
      end
      m_sl = 0; m_sm = 0;
      return;
    end
    if (m_sl < STAT_MAX) m_sl++;
    if (v.uv && v.um && m_sm < STAT_MAX) m_sm++;
    if (v.flush) begin
      for (int k = 0; k < int'(ENTRIES); k++) m_valid[k] = 0;
    end else if (v.uv) begin
      i   = idx_of(v.upc);
      hit = m_valid[i] && (m_tag[i] == tag_of(v.upc));
      if (hit) begin
        if (v.ut) begin
          if (m_ctr[i] < 3) m_ctr[i]++;
          m_tgt[i] = v.utgt;
        end else if (m_ctr[i] > 0) begin
          m_ctr[i]--;
        end
      end else if (v.ut) begin
        m_valid[i] = 1; m_tag[i] = tag_of(v.upc); m_tgt[i] = v.utgt; m_ctr[i] = 2;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input in_t v);
    @(negedge CLK);
    CLR = v.clr; FLUSH_All = v.flush; UPD_Valid = v.uv; UPD_PC = v.upc;
    UPD_Taken = v.ut; UPD_Target = v.utgt; UPD_Mispredict = v.um; LKP_PC = v.lpc;
    #1;
  endtask

  task automatic check_stats(input string tag);
    check({tag, ".lookups"},     32'(STAT_Lookups),     32'(m_sl));
    check({tag, ".mispredicts"}, 32'(STAT_Mispredicts), 32'(m_sm));
  endtask

  function automatic vec_t mk(input bit clr, input bit flush, input bit uv,
                              input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                              input bit um, input logic [31:0] lpc,
                              input bit hit, input bit tk, input logic [31:0] nxt);
    vec_t v;
    v.i.clr = clr; v.i.flush = flush; v.i.uv = uv; v.i.upc = upc; v.i.ut = ut;
    v.i.utgt = utgt; v.i.um = um; v.i.lpc = lpc;
    v.hit = hit; v.tk = tk; v.nxt = nxt;
    return v;
  endfunction

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 15) == 0) return $urandom;
    return 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
  endfunction

  vec_t tbl [19];

  initial begin
    in_t v;
    bit  e_hit, e_tk;
    logic [31:0] e_nxt;

    //        clr fl uv upc           ut utgt        um lpc            hit tk nxt
    tbl[0]  = mk(1, 0, 0, 32'h0,       0, 32'h0,     0, 32'h40,       0, 0, 32'h44);
    tbl[1]  = mk(0, 0, 1, 32'h40,      1, 32'h100,   0, 32'h40,       0, 0, 32'h44);
    tbl[2]  = mk(0, 0, 1, 32'h40,      0, 32'h0,     1, 32'h40,       1, 1, 32'h100);
    tbl[3]  = mk(0, 0, 1, 32'h40,      0, 32'h0,     0, 32'h40,       1, 0, 32'h44);
    tbl[4]  = mk(0, 0, 1, 32'h40,      1, 32'h200,   1, 32'h40,       1, 0, 32'h44);
    tbl[5]  = mk(0, 0, 1, 32'h40,      1, 32'h200,   0, 32'h40,       1, 0, 32'h44);
    tbl[6]  = mk(0, 0, 1, 32'h40,      1, 32'h200,   0, 32'h40,       1, 1, 32'h200);
    tbl[7]  = mk(0, 0, 1, 32'h40,      1, 32'h200,   0, 32'h40,       1, 1, 32'h200);
    tbl[8]  = mk(0, 0, 1, 32'h40,      0, 32'h0,     0, 32'h40,       1, 1, 32'h200);
    tbl[9]  = mk(0, 0, 0, 32'h0,       0, 32'h0,     0, 32'h40,       1, 1, 32'h200);
    tbl[10] = mk(0, 0, 1, 32'h80,      1, 32'h300,   0, 32'h40,       1, 1, 32'h200);
    tbl[11] = mk(0, 0, 1, 32'hC4,      0, 32'h999,   1, 32'h40,       0, 0, 32'h44);
    tbl[12] = mk(0, 0, 0, 32'h0,       0, 32'h0,     0, 32'hC4,       0, 0, 32'hC8);
    tbl[13] = mk(0, 0, 1, 32'h80,      0, 32'h0,     0, 32'h80,       1, 1, 32'h300);
    tbl[14] = mk(0, 1, 1, 32'h80,      1, 32'h400,   1, 32'h80,       1, 0, 32'h84);
    tbl[15] = mk(0, 0, 0, 32'h0,       0, 32'h0,     0, 32'h80,       0, 0, 32'h84);
    tbl[16] = mk(0, 0, 1, 32'h40,      1, 32'h600,   0, 32'hFFFFFFFC, 0, 0, 32'h0);
    tbl[17] = mk(1, 0, 1, 32'h40,      1, 32'h500,   1, 32'h40,       0, 0, 32'h44);
    tbl[18] = mk(0, 0, 0, 32'h0,       0, 32'h0,     0, 32'h40,       0, 0, 32'h44);

    for (int k = 0; k < 19; k++) begin
      drive(tbl[k].i);
      check($sformatf("tbl%0d.hit", k),   32'(PRED_Hit),   32'(tbl[k].hit));
      check($sformatf("tbl%0d.taken", k), 32'(PRED_Taken), 32'(tbl[k].tk));
      check($sformatf("tbl%0d.next", k),  PRED_Next_PC,    tbl[k].nxt);
      if (k > 0) check_stats($sformatf("tbl%0d", k));
      model_step(tbl[k].i);
    end

    // Random traffic; the model is in step with the DUT after tbl[17]'s reset.
    for (int c = 0; c < 800; c++) begin
      v.clr   = ($urandom_range(0, 63) == 0);
      v.flush = ($urandom_range(0, 31) == 0);
      v.uv    = $urandom_range(0, 1) == 1;
      v.upc   = rnd_pc();
      v.ut    = $urandom_range(0, 2) != 0;
      v.utgt  = $urandom & 32'hFFFF_FFFC;
      v.um    = $urandom_range(0, 1) == 1;
      v.lpc   = rnd_pc();
      drive(v);
      model_predict(v.lpc, v.clr, e_hit, e_tk, e_nxt);
      check($sformatf("rnd%0d.hit", c),   32'(PRED_Hit),   32'(e_hit));
      check($sformatf("rnd%0d.taken", c), 32'(PRED_Taken), 32'(e_tk));
      check($sformatf("rnd%0d.next", c),  PRED_Next_PC,    e_nxt);
      check_stats($sformatf("rnd%0d", c));
      model_step(v);
    end

    // Twenty mispredicting updates saturate the 4-bit stat at 15; CLR zeroes it.
    v = '{clr: 1, flush: 0, uv: 0, ut: 0, um: 0, upc: 32'h0, utgt: 32'h0, lpc: 32'h40};
    drive(v); model_step(v);
    v = '{clr: 0, flush: 0, uv: 1, ut: 0, um: 1, upc: 32'h1000, utgt: 32'h0, lpc: 32'h40};
    for (int c = 0; c < 20; c++) begin
      drive(v); model_step(v);
    end
    v = '{clr: 0, flush: 0, uv: 0, ut: 0, um: 0, upc: 32'h0, utgt: 32'h0, lpc: 32'h1000};
    drive(v);
    check("sat.mispredicts", 32'(STAT_Mispredicts), 32'd15);
    check("sat.lookups",     32'(STAT_Lookups),     32'd15);
    check("sat.no_alloc",    32'(PRED_Hit),         32'd0);
    model_step(v);
    v.clr = 1;
    drive(v); model_step(v);
    v.clr = 0;
    drive(v);
    check("clr.mispredicts", 32'(STAT_Mispredicts), 32'd0);
    check("clr.lookups",     32'(STAT_Lookups),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
